// File: rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl.sv
// nios_system_nios2_gen2_0_cpu_ocimem_ctrl: debug RAM shared by JTAG commands and a CPU Avalon slave; define OCIMEM_CPU_WRITE_PROTECT_EN to drop CPU writes while debugack=0
module nios_system_nios2_gen2_0_cpu_ocimem_ctrl #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              debugack,
  output logic [31:0]       MonDReg,
  input  logic [RAM_AW-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);
  typedef enum logic [2:0] {IDLE, J_RD, J_RD_DONE, J_WR, C_RD, C_RD_DONE, C_WR} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_NA, CMD_B} cmd_t;
  state_t state_q, state_d;
  cmd_t pend_q, pend_d, pulse_cmd, cmd;
  logic [35:3] pend_jdo_q, pend_jdo_d, cmd_jdo;
  logic [RAM_AW-1:0] mon_a_q, mon_a_d, ram_addr;
  logic [31:0] mon_d_q, mon_d_d, wdata_q, wdata_d, ram_wdata, ram_q;
  logic ram_we, cpu_we, unused_ok;
  logic [31:0] mem [2**RAM_AW];
`ifdef OCIMEM_CPU_WRITE_PROTECT_EN
  assign cpu_we = debugack;
  assign unused_ok = ^{jdo[37:36], jdo[2:0]};
`else
  assign cpu_we = 1'b1;
  assign unused_ok = ^{debugack, jdo[37:36], jdo[2:0]};
`endif
  // Command decode, one-deep pending slot and FSM next state; a pulse seen in IDLE is acted on at once
  always_comb begin
    if (take_action_ocimem_b) pulse_cmd = CMD_B;
    else if (take_action_ocimem_a) pulse_cmd = CMD_A;
    else if (take_no_action_ocimem_a) pulse_cmd = CMD_NA;
    else pulse_cmd = CMD_NONE;
    cmd = pend_q;
    cmd_jdo = pend_jdo_q;
    if (pulse_cmd != CMD_NONE) begin
      cmd = pulse_cmd;
      cmd_jdo = jdo[35:3];
    end
    pend_d = pend_q;
    pend_jdo_d = pend_jdo_q;
    if (state_q == IDLE) pend_d = CMD_NONE;
    else if (pulse_cmd != CMD_NONE) begin
      pend_d = pulse_cmd;
      pend_jdo_d = jdo[35:3];
    end
    state_d = state_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE:
        if (cmd == CMD_B) begin
          wdata_d = cmd_jdo[34:3];
          state_d = J_WR;
        end else if (cmd == CMD_A) begin
          mon_a_d = cmd_jdo[26 +: RAM_AW];
          if (cmd_jdo[35]) state_d = J_RD;
        end else if (cmd == CMD_NA) begin
          mon_a_d = mon_a_q + 1'b1;
          state_d = J_RD;
        end else if (avs_write) state_d = C_WR;
        else if (avs_read) state_d = C_RD;
      J_RD: state_d = J_RD_DONE;
      J_RD_DONE: begin
        mon_d_d = ram_q;
        state_d = IDLE;
      end
      J_WR: begin
        mon_a_d = mon_a_q + 1'b1;
        state_d = IDLE;
      end
      C_RD: state_d = C_RD_DONE;
      default: state_d = IDLE;
    endcase
  end
  // RAM port steering: CPU states use the bus address, JTAG states use MonAReg
  always_comb begin
    ram_addr = (state_q == C_RD || state_q == C_WR) ? avs_address : mon_a_q;
    ram_we = !reset && (state_q == J_WR || (state_q == C_WR && cpu_we));
    ram_wdata = (state_q == C_WR) ? avs_writedata : wdata_q;
  end
  // Single-port RAM with registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= reset ? '0 : mem[ram_addr];
  end
  // Control and JTAG register state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q <= CMD_NONE;
      mon_a_q <= '0;
      mon_d_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
    end
    pend_jdo_q <= pend_jdo_d;
    wdata_q <= wdata_d;
  end
  assign MonDReg = mon_d_q;
  assign avs_readdata = ram_q;
  assign avs_waitrequest = (avs_read || avs_write) && !(state_q == C_RD_DONE || state_q == C_WR);
endmodule

// File: tb/tb_nios_system_nios2_gen2_0_cpu_ocimem_ctrl.sv
// tb_nios_system_nios2_gen2_0_cpu_ocimem_ctrl: randomized scoreboard bench for the OCI debug RAM controller
module tb_nios_system_nios2_gen2_0_cpu_ocimem_ctrl;
`ifdef OCIMEM_CPU_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic [37:0] jdo = '0;
  logic ta_a = 0, ta_na = 0, ta_b = 0, debugack = 1;
  logic [31:0] MonDReg, avs_readdata, avs_writedata = '0;
  logic [7:0] avs_address = '0;
  logic avs_read = 0, avs_write = 0, avs_waitrequest;
  int tests = 0, fails = 0;
  logic [31:0] mem_m [256];
  logic [7:0] ma = '0;
  logic [31:0] md = '0;
  logic [31:0] exp_q [$];
  nios_system_nios2_gen2_0_cpu_ocimem_ctrl #(.RAM_AW(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(ta_na), .take_action_ocimem_b(ta_b),
    .debugack(debugack), .MonDReg(MonDReg),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Monitor: every completed CPU read is compared against the oldest queued expectation
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!reset && avs_read && !avs_write && !avs_waitrequest) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cpu_rd_unexpected: got %h expected no completion", avs_readdata);
      end else begin
        e = exp_q.pop_front();
        chk("cpu_rd", avs_readdata, e);
      end
    end
  end
  // CPU transfer; n is the number of sampled cycles up to and including completion
  task automatic cpu_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, output int n);
    n = 0;
    avs_address = a;
    avs_writedata = d;
    avs_write = wr;
    avs_read = !wr;
    if (!wr) exp_q.push_back(mem_m[a]);
    else if (!PROT || debugack) mem_m[a] = d;
    do begin
      @(negedge clk);
      n++;
    end while (avs_waitrequest && n < 20);
    if (avs_waitrequest) begin
      tests++;
      fails++;
      $display("FAIL cpu_timeout: got waitrequest=1 expected 0 within 20 cycles");
    end
    @(posedge clk);
    #1;
    avs_read = 0;
    avs_write = 0;
  endtask
  // JTAG command: 0=ocimem_a, 1=no_action_a, 2=ocimem_b; MonDReg checked exactly 2 cycles after the pulse
  task automatic jtag(input int kind, input logic [7:0] a, input bit rd, input logic [31:0] d);
    logic [37:0] j;
    j = {6'($urandom), $urandom};
    if (kind == 0) begin
      j[35] = rd;
      j[33:26] = a;
      ta_a = 1;
      ma = a;
      if (rd) md = mem_m[ma];
    end else if (kind == 1) begin
      ta_na = 1;
      ma = ma + 8'd1;
      md = mem_m[ma];
    end else begin
      j[34:3] = d;
      ta_b = 1;
      mem_m[ma] = d;
      ma = ma + 8'd1;
    end
    jdo = j;
    @(posedge clk);
    #1;
    ta_a = 0;
    ta_na = 0;
    ta_b = 0;
    jdo = {6'($urandom), $urandom};
    repeat (3) @(negedge clk);
    chk(kind == 2 ? "jtag_wr_mondreg" : "jtag_rd_mondreg", MonDReg, md);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    logic [31:0] d1, d2;
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [31:0] d1, d2;
    logic [37:0] j;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_waitreq", 32'(avs_waitrequest), 32'h0);
    avs_read = 1;
    #1;
    chk("idle_waitreq_rd", 32'(avs_waitrequest), 32'h1);
    avs_read = 0;
    @(posedge clk);
    #1;
    debugack = 1;
    for (int i = 0; i < 256; i++) cpu_xfer(1, 8'(i), $urandom, n);
    jtag(0, 8'h10, 0, 0);
    jtag(2, 0, 0, 32'hDEADBEEF);
    jtag(0, 8'h10, 1, 0);
    chk("deadbeef", MonDReg, 32'hDEADBEEF);
    jtag(1, 0, 0, 0);
    jtag(0, 8'hFF, 0, 0);
    jtag(1, 0, 0, 0);
    cpu_xfer(1, 8'h05, 32'h12345678, n);
    chk("wr_latency", 32'(n), 32'd2);
    cpu_xfer(0, 8'h05, 0, n);
    chk("rd_latency", 32'(n), 32'd3);
    jtag(0, 8'h20, 0, 0);
    d1 = $urandom;
    d2 = $urandom;
    j = {6'($urandom), $urandom};
    j[34:3] = d1;
    jdo = j;
    ta_b = 1;
    avs_address = 8'h20;
    avs_writedata = d2;
    avs_write = 1;
    @(posedge clk);
    #1;
    ta_b = 0;
    @(negedge clk);
    chk("cc_waitreq_jwr", 32'(avs_waitrequest), 32'h1);
    @(negedge clk);
    chk("cc_waitreq_idle", 32'(avs_waitrequest), 32'h1);
    @(negedge clk);
    chk("cc_waitreq_cwr", 32'(avs_waitrequest), 32'h0);
    @(posedge clk);
    #1;
    avs_write = 0;
    mem_m[8'h20] = d2;
    ma = 8'h21;
    cpu_xfer(0, 8'h20, 0, n);
    jtag(0, 8'h20, 1, 0);
    fork
      cpu_xfer(0, 8'h44, 0, n);
      begin
        @(posedge clk);
        #1;
        j = {6'($urandom), $urandom};
        j[35] = 1;
        j[33:26] = 8'h40;
        jdo = j;
        ta_a = 1;
        @(posedge clk);
        #1;
        ta_a = 0;
        ta_na = 1;
        @(posedge clk);
        #1;
        ta_na = 0;
      end
    join
    ma = ma + 8'd1;
    md = mem_m[ma];
    repeat (4) @(posedge clk);
    #1;
    chk("pend_overwrite", MonDReg, md);
    j = {6'($urandom), $urandom};
    j[35] = 1;
    j[33:26] = 8'h33;
    jdo = j;
    ta_a = 1;
    @(posedge clk);
    #1;
    ta_a = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    ma = 0;
    md = 0;
    chk("rstjrd_mondreg", MonDReg, 32'h0);
    chk("rstjrd_readdata", avs_readdata, 32'h0);
    chk("rstjrd_waitreq", 32'(avs_waitrequest), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstjrd_abandoned", MonDReg, 32'h0);
    jtag(1, 0, 0, 0);
    debugack = 0;
    cpu_xfer(1, 8'h30, 32'hA5A5A5A5, n);
    cpu_xfer(0, 8'h30, 0, n);
    debugack = 1;
    cpu_xfer(1, 8'h30, 32'hA5A5A5A5, n);
    cpu_xfer(0, 8'h30, 0, n);
    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 4);
      debugack = 1'($urandom);
      if (k < 3) jtag(k, 8'($urandom), 1'($urandom), $urandom);
      else cpu_xfer(k == 3, 8'($urandom), $urandom, n);
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
